// File: rtl/arith_calc_module_pkg.sv
// Shared definitions for the two-operand calculator: op codes, one-hot
// FSM encoding, fixed LCD line texts and the nibble-to-ASCII helper.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    localparam logic [4:0] S_START     = 5'b00001;
    localparam logic [4:0] S_LOAD_A    = 5'b00010;
    localparam logic [4:0] S_LOAD_B    = 5'b00100;
    localparam logic [4:0] S_CALCULATE = 5'b01000;
    localparam logic [4:0] S_DONE      = 5'b10000;

    typedef enum logic [4:0] {
        ST_START     = S_START,
        ST_LOAD_A    = S_LOAD_A,
        ST_LOAD_B    = S_LOAD_B,
        ST_CALCULATE = S_CALCULATE,
        ST_DONE      = S_DONE
    } state_e;

    // 16-character LCD lines
    localparam logic [127:0] TXT_NAME_ADD = "Addition        ";
    localparam logic [127:0] TXT_NAME_SUB = "Subtraction     ";
    localparam logic [127:0] TXT_NAME_AND = "Bitwise AND     ";
    localparam logic [127:0] TXT_NAME_XOR = "Bitwise XOR     ";
    localparam logic [127:0] TXT_PRESS    = "Press Btnc      ";
    localparam logic [127:0] TXT_INPUT1   = "Input 1st #     ";
    localparam logic [127:0] TXT_INPUT2   = "Input 2nd #     ";
    localparam logic [127:0] TXT_THEN     = "Then Press Btnc ";
    localparam logic [127:0] TXT_RES_ADD  = "The Sum is:     ";
    localparam logic [127:0] TXT_RES_SUB  = "The Diff is:    ";
    localparam logic [127:0] TXT_RES_AND  = "The AND is:     ";
    localparam logic [127:0] TXT_RES_XOR  = "The XOR is:     ";

    // Uppercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [127:0] start_line(input op_e op);
        case (op)
            OP_ADD:  return TXT_NAME_ADD;
            OP_SUB:  return TXT_NAME_SUB;
            OP_AND:  return TXT_NAME_AND;
            default: return TXT_NAME_XOR;
        endcase
    endfunction

    function automatic logic [127:0] done_line(input op_e op);
        case (op)
            OP_ADD:  return TXT_RES_ADD;
            OP_SUB:  return TXT_RES_SUB;
            OP_AND:  return TXT_RES_AND;
            default: return TXT_RES_XOR;
        endcase
    endfunction

endpackage

// File: rtl/arith_calc_module_if.sv
// Menu-side bundle of the calculator: user inputs in, result and LCD text out.
interface arith_calc_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             next;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] result;
    logic             flag;
    logic             done;
    logic [255:0]     textOut;

    modport master (
        output enable, next, op, data_in,
        input  result, flag, done, textOut
    );

    modport slave (
        input  enable, next, op, data_in,
        output result, flag, done, textOut
    );
endinterface

// File: rtl/arith_calc_module_fmt.sv
// Combinational WIDTH-bit value to ASCII hex string, most significant digit
// in the highest byte so it appears first on the LCD.
module hex_ascii_fmt
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         mag_i,
    output logic [(WIDTH/4)*8-1:0]   str_o
);

    // One ASCII character per nibble
    always_comb begin
        str_o = '0;
        for (int k = 0; k < WIDTH/4; k++) begin
            str_o[k*8 +: 8] = hex2ascii(mag_i[k*4 +: 4]);
        end
    end

endmodule

// File: rtl/arith_calc_module.sv
// Two-operand calculator: loads A and B from the switches on successive
// button presses, applies ADD/SUB/AND/XOR and presents the result on a
// 32-character LCD string.
module arith_calc_module
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        Clk,
    input  logic        reset_n,
    arith_calc_if.slave bus
);

    localparam int NDIG = WIDTH / 4;
    localparam int NPAD = 14 - NDIG;   // sign + digits + carry char + pad = 16

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               next_q;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               flag_q, flag_d;
    logic [255:0]       text_q, text_d;

    logic               nxt;
    op_e                op_live;
    logic [WIDTH:0]     sum_w;
    logic               a_lt_b;
    logic               neg_show;
    logic [WIDTH-1:0]   mag;
    logic [NDIG*8-1:0]  hex_str;
    logic [7:0]         sign_chr;
    logic [7:0]         carry_chr;

    // Only the rising edge of the debounced button counts as an event
    assign nxt     = bus.next & ~next_q;
    assign op_live = op_e'(bus.op);
    assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
    assign a_lt_b  = (a_q < b_q);

    // FSM next state and operand/result datapath
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flag_d   = flag_q;
        if ((state_q != ST_START) && !bus.enable) begin
            state_d = ST_START;
        end else begin
            case (state_q)
                ST_START: begin
                    if (nxt && bus.enable) begin
                        op_d    = op_live;
                        a_d     = '0;
                        b_d     = '0;
                        state_d = ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (nxt) begin
                        a_d     = bus.data_in;
                        state_d = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (nxt) begin
                        b_d     = bus.data_in;
                        state_d = ST_CALCULATE;
                    end
                end
                ST_CALCULATE: begin
                    case (op_q)
                        OP_ADD: begin
                            result_d = sum_w[WIDTH-1:0];
                            flag_d   = sum_w[WIDTH];
                        end
                        OP_SUB: begin
                            result_d = a_q - b_q;
                            flag_d   = a_lt_b;
                        end
                        OP_AND: begin
                            result_d = a_q & b_q;
                            flag_d   = 1'b0;
                        end
                        default: begin
                            result_d = a_q ^ b_q;
                            flag_d   = 1'b0;
                        end
                    endcase
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (nxt) begin
                        state_d = ST_START;
                    end
                end
                default: state_d = ST_START;
            endcase
        end
    end

    // A negative difference is shown as '-' plus magnitude; the port keeps A-B
    assign neg_show  = (op_q == OP_SUB) && a_lt_b;
    assign mag       = neg_show ? (b_q - a_q) : result_d;
    assign sign_chr  = neg_show ? 8'h2D : 8'h20;
    assign carry_chr = ((op_q == OP_ADD) && flag_d) ? 8'h43 : 8'h20;

    hex_ascii_fmt #(.WIDTH(WIDTH)) u_fmt (
        .mag_i (mag),
        .str_o (hex_str)
    );

    // Text follows the state being entered so the LCD never lags the FSM
    always_comb begin
        text_d = text_q;
        case (state_d)
            ST_START:  text_d = {start_line(op_live), TXT_PRESS};
            ST_LOAD_A: text_d = {TXT_INPUT1, TXT_THEN};
            ST_LOAD_B: text_d = {TXT_INPUT2, TXT_THEN};
            ST_DONE:   text_d = {done_line(op_q), sign_chr, hex_str, carry_chr, {NPAD{8'h20}}};
            default:   text_d = text_q;
        endcase
    end

    // State, operands, result and LCD text registers
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_START;
            op_q     <= OP_ADD;
            next_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            text_q   <= {TXT_NAME_ADD, TXT_PRESS};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            next_q   <= bus.next;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            text_q   <= text_d;
        end
    end

    assign bus.result  = result_q;
    assign bus.flag    = flag_q;
    assign bus.done    = (state_q == ST_DONE);
    assign bus.textOut = text_q;

endmodule

// File: tb/tb_arith_calc_module.sv
// Bench for arith_calc_module: a WIDTH=8 and a WIDTH=16 instance share the
// same stimulus; each has its own expectation queue and monitor.
module tb_arith_calc_module;

    typedef struct {
        logic [31:0]  res;
        logic         flag;
        logic [255:0] text;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, nx;
    logic [1:0]  opv;
    logic [15:0] din;

    int passed = 0;
    int total  = 0;

    exp_t q8[$];
    exp_t q16[$];
    logic [31:0] last8, last16;
    logic d8_prev  = 1'b0;
    logic d16_prev = 1'b0;

    always #5 clk = ~clk;

    arith_calc_if #(.WIDTH(8))  if8 ();
    arith_calc_if #(.WIDTH(16)) if16 ();

    assign if8.enable   = en;
    assign if8.next     = nx;
    assign if8.op       = opv;
    assign if8.data_in  = din[7:0];
    assign if16.enable  = en;
    assign if16.next    = nx;
    assign if16.op      = opv;
    assign if16.data_in = din;

    arith_calc_module #(.WIDTH(8)) dut8 (
        .Clk     (clk),
        .reset_n (rst_n),
        .bus     (if8.slave)
    );

    arith_calc_module #(.WIDTH(16)) dut16 (
        .Clk     (clk),
        .reset_n (rst_n),
        .bus     (if16.slave)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] hexc(input longint unsigned n);
        if (n < 10) return 8'h30 + n[7:0];
        return 8'h37 + n[7:0];
    endfunction

    function automatic logic [255:0] start_text(input logic [1:0] o);
        logic [127:0] name;
        case (o)
            2'd0:    name = "Addition        ";
            2'd1:    name = "Subtraction     ";
            2'd2:    name = "Bitwise AND     ";
            default: name = "Bitwise XOR     ";
        endcase
        return {name, 128'("Press Btnc      ")};
    endfunction

    // Reference: plain wide arithmetic, then place characters by LCD position
    function automatic exp_t model(input int w, input logic [1:0] o,
                                   input logic [15:0] a_in, input logic [15:0] b_in);
        exp_t e;
        longint unsigned mask, a, b, r, mag;
        bit f, neg;
        logic [127:0] l1;
        int nd;
        mask = (64'd1 << w) - 1;
        a = {48'd0, a_in} & mask;
        b = {48'd0, b_in} & mask;
        f = 0;
        neg = 0;
        case (o)
            2'd0: begin r = a + b; f = ((r >> w) != 0); l1 = "The Sum is:     "; end
            2'd1: begin r = a - b; f = (a < b); neg = f; l1 = "The Diff is:    "; end
            2'd2: begin r = a & b; l1 = "The AND is:     "; end
            default: begin r = a ^ b; l1 = "The XOR is:     "; end
        endcase
        r = r & mask;
        mag = neg ? (b - a) : r;
        e.text = {l1, {16{8'h20}}};
        if (neg) e.text[255-8*16 -: 8] = 8'h2D;
        nd = w / 4;
        for (int d = 0; d < nd; d++)
            e.text[255-8*(17+d) -: 8] = hexc((mag >> (4*(nd-1-d))) & 64'hF);
        if (o == 2'd0 && f) e.text[255-8*(17+nd) -: 8] = 8'h43;
        e.res  = r[31:0];
        e.flag = f;
        return e;
    endfunction

    // Monitors: compare on every rising edge of done
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if8.done && !d8_prev) begin
            if (q8.size() == 0) begin
                chk("sb8_unexpected_done", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("sb8_result", {248'd0, if8.result}, {224'd0, e.res});
                chk("sb8_flag", {255'd0, if8.flag}, {255'd0, e.flag});
                chk("sb8_text", if8.textOut, e.text);
            end
        end
        d8_prev = if8.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if16.done && !d16_prev) begin
            if (q16.size() == 0) begin
                chk("sb16_unexpected_done", 1, 0);
            end else begin
                e = q16.pop_front();
                chk("sb16_result", {240'd0, if16.result}, {224'd0, e.res});
                chk("sb16_flag", {255'd0, if16.flag}, {255'd0, e.flag});
                chk("sb16_text", if16.textOut, e.text);
            end
        end
        d16_prev = if16.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        nx = 1'b1;
        tick();
        nx = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 10 && !(if8.done && if16.done); i++) tick();
        chk("done8_seen", {255'd0, if8.done}, 1);
        chk("done16_seen", {255'd0, if16.done}, 1);
    endtask

    // From LOAD_B: queue expectations, load B, wait for DONE
    task automatic finish_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t e8, e16;
        e8  = model(8, o, a, b);
        e16 = model(16, o, a, b);
        q8.push_back(e8);
        q16.push_back(e16);
        last8  = e8.res;
        last16 = e16.res;
        din = b;
        press();
        wait_done();
    endtask

    // From START: full transaction ending in DONE; op input scrambled after START
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        opv = o;
        press();
        opv = 2'($urandom_range(0, 3));
        din = a;
        press();
        finish_op(o, a, b);
    endtask

    task automatic back_to_start();
        press();
        chk("done8_cleared", {255'd0, if8.done}, 0);
        chk("done16_cleared", {255'd0, if16.done}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        nx    = 1'b0;
        opv   = 2'd0;
        din   = 16'd0;
        last8 = 0;
        last16 = 0;
        #12;
        chk("rst_result8", {248'd0, if8.result}, 0);
        chk("rst_flag8", {255'd0, if8.flag}, 0);
        chk("rst_done8", {255'd0, if8.done}, 0);
        chk("rst_text8", if8.textOut, start_text(2'd0));
        chk("rst_text16", if16.textOut, start_text(2'd0));
        rst_n = 1'b1;
        en    = 1'b1;
        tick();

        // Directed arithmetic cases
        run_op(2'd0, 16'h003C, 16'h004F);
        chk("t1_result8", {248'd0, if8.result}, 8'h8B);
        chk("t1_flag8", {255'd0, if8.flag}, 0);
        back_to_start();
        run_op(2'd0, 16'h00F0, 16'h0020);
        chk("t2_result8", {248'd0, if8.result}, 8'h10);
        chk("t2_flag8", {255'd0, if8.flag}, 1);
        back_to_start();
        run_op(2'd1, 16'h0005, 16'h0012);
        chk("t3_result8", {248'd0, if8.result}, 8'hF3);
        chk("t3_flag8", {255'd0, if8.flag}, 1);
        back_to_start();
        run_op(2'd1, 16'h7777, 16'h7777);
        chk("t3_eq_result16", {240'd0, if16.result}, 0);
        chk("t3_eq_flag16", {255'd0, if16.flag}, 0);
        back_to_start();

        // Held button in LOAD_A is a single event
        opv = 2'd0;
        press();
        din = 16'h1234;
        nx  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            din = 16'($urandom);
        end
        chk("held_text8", if8.textOut, {128'("Input 2nd #     "), 128'("Then Press Btnc ")});
        chk("held_done8", {255'd0, if8.done}, 0);
        nx = 1'b0;
        tick();
        finish_op(2'd0, 16'h1234, 16'h4321);
        back_to_start();

        // Enable dropped in LOAD_B aborts to START, result held
        opv = 2'd1;
        press();
        din = 16'h00AA;
        press();
        en = 1'b0;
        tick();
        chk("abort_text8", if8.textOut, start_text(2'd1));
        chk("abort_done8", {255'd0, if8.done}, 0);
        chk("abort_hold8", {248'd0, if8.result}, {224'd0, last8});
        chk("abort_hold16", {240'd0, if16.result}, {224'd0, last16});
        en = 1'b1;
        tick();

        // Asynchronous reset in DONE
        run_op(2'd0, 16'hFFFF, 16'h0001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_done8", {255'd0, if8.done}, 0);
        chk("arst_result8", {248'd0, if8.result}, 0);
        chk("arst_flag16", {255'd0, if16.flag}, 0);
        chk("arst_text16", if16.textOut, start_text(2'd0));
        #1 rst_n = 1'b1;
        tick();

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            back_to_start();
        end

        // XOR at 16 bits, then live op shown in START
        run_op(2'd3, 16'hA5A5, 16'h0FF0);
        chk("t6_result16", {240'd0, if16.result}, 16'hAA55);
        opv = 2'd2;
        back_to_start();
        chk("t6_live_and", if16.textOut, start_text(2'd2));
        opv = 2'd1;
        tick();
        chk("t6_live_sub", if16.textOut, start_text(2'd1));

        tick();
        chk("sb8_drained", 256'(q8.size()), 0);
        chk("sb16_drained", 256'(q16.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
